// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands, detects load-use hazards,
// and handles bubbles, stall hold with writeback refresh, and flush.
module id_ex_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             ex_stall,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic [159:0]     idex_reg,
  output logic             idex_valid,
  output logic             id_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  // First member lands in the top bits, so this matches the bundle layout.
  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] b;
    logic [31:0] a;
    logic [31:0] pc;
    logic [31:0] instr;
  } idex_t;

  idex_t      q;
  logic       load_in_ex;
  logic [4:0] ld_dest;
  logic       load_use;
  logic       wb_ok;
  logic [31:0] id_a, id_b;

  assign idex_reg = q;
  assign ld_dest  = q.instr[20:16];
  assign wb_ok    = wb_we && (wb_addr != 5'd0);

  always_comb begin
    load_in_ex = 1'b0;
    if (idex_valid) begin
      case (q.instr[31:26])
        6'b100011, 6'b100000, 6'b100100: load_in_ex = 1'b1;
        default:                         load_in_ex = 1'b0;
      endcase
    end
  end

  assign load_use = load_in_ex && id_valid && (ld_dest != 5'd0) &&
                    ((ld_dest == id_instr[25:21]) || (ld_dest == id_instr[20:16]));

  // Flush kills ID upstream, so there is nothing to stall for.
  assign id_stall = !rst && !flush && (ex_stall || load_use);

  // Same-edge writeback bypass into the incoming operands.
  assign id_a = (wb_ok && wb_addr == id_instr[25:21]) ? wb_data : id_rs_data;
  assign id_b = (wb_ok && wb_addr == id_instr[20:16]) ? wb_data : id_rt_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      idex_valid <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush || (!ex_stall && load_use)) begin
      q          <= '0;
      idex_valid <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (ex_stall) begin
      // Held instruction keeps its operands fresh from writeback.
      if (idex_valid && wb_ok) begin
        if (wb_addr == q.instr[25:21]) q.a <= wb_data;
        if (wb_addr == q.instr[20:16]) q.b <= wb_data;
      end
    end else begin
      idex_valid <= id_valid;
      q.instr    <= id_instr;
      q.pc       <= id_pc;
      q.a        <= id_a;
      q.b        <= id_b;
      q.imm      <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vectors, a behavioural model compared
// every cycle, and literal checks at the interesting points.
module tb_id_ex_stage_reg;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, ex_stall = 0, flush = 0, wb_we = 0;
  logic [31:0] id_instr = 0, id_pc = 0, id_rs_data = 0, id_rt_data = 0, id_imm = 0, wb_data = 0;
  logic [4:0]  wb_addr = 0;
  logic [159:0] idex_reg;
  logic idex_valid, id_stall;
  logic [CNT_W-1:0] bubble_cnt;

  int tests = 0, fails = 0;

  id_ex_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .ex_stall(ex_stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .idex_reg(idex_reg), .idex_valid(idex_valid),
    .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: separate named fields and an integer counter.
  logic [31:0] m_instr, m_pc, m_a, m_b, m_imm;
  logic        m_valid;
  int          m_cnt;

  function automatic bit m_hazard();
    bit is_load;
    int dest;
    is_load = m_valid && (m_instr[31:26] == 6'h23 || m_instr[31:26] == 6'h20 ||
                          m_instr[31:26] == 6'h24);
    dest = m_instr[20:16];
    return is_load && id_valid && dest != 0 &&
           (dest == int'(id_instr[25:21]) || dest == int'(id_instr[20:16]));
  endfunction

  function automatic logic [31:0] m_src(logic [4:0] r, logic [31:0] rf);
    return (wb_we && wb_addr != 0 && wb_addr == r) ? wb_data : rf;
  endfunction

  task automatic m_bubble();
    {m_instr, m_pc, m_a, m_b, m_imm} = '0;
    m_valid = 1'b0;
    m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_instr, m_pc, m_a, m_b, m_imm} = '0;
      m_valid = 1'b0;
      m_cnt = 0;
    end else if (flush) m_bubble();
    else if (ex_stall) begin
      if (m_valid && wb_we && wb_addr != 0) begin
        if (wb_addr == m_instr[25:21]) m_a = wb_data;
        if (wb_addr == m_instr[20:16]) m_b = wb_data;
      end
    end else if (m_hazard()) m_bubble();
    else begin
      m_valid = id_valid; m_instr = id_instr; m_pc = id_pc; m_imm = id_imm;
      m_a = m_src(id_instr[25:21], id_rs_data);
      m_b = m_src(id_instr[20:16], id_rt_data);
    end
  end

  // Inputs change 1 time unit after posedge, so mid-cycle everything is settled.
  always @(negedge clk) begin
    chk("model_idex_reg", idex_reg, {m_imm, m_b, m_a, m_pc, m_instr});
    chk("model_idex_valid", idex_valid, m_valid);
    chk("model_bubble_cnt", bubble_cnt, m_cnt[CNT_W-1:0]);
    chk("model_id_stall", id_stall, !rst && !flush && (ex_stall || m_hazard()));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_id(logic [31:0] ins, logic [31:0] pc, logic [31:0] rs, logic [31:0] rt);
    id_valid = 1'b1; id_instr = ins; id_pc = pc; id_rs_data = rs; id_rt_data = rt;
    id_imm = pc ^ 32'h0000_FFFF;
  endtask

  localparam logic [31:0] ADD123 = 32'h0043_0820;  // add $1,$2,$3
  localparam logic [31:0] LW5    = 32'h8C25_0000;  // lw $5,0($1)
  localparam logic [31:0] ADD657 = 32'h00A7_3020;  // add $6,$5,$7
  localparam logic [31:0] ADD140 = 32'h0080_0820;  // add $1,$4,$0
  localparam logic [31:0] ADD199 = 32'h0129_0820;  // add $1,$9,$9

  initial begin
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_reg", idex_reg, 160'h0);
    chk("reset_valid", idex_valid, 1'b0);
    chk("reset_cnt", bubble_cnt, 4'h0);

    // First edge after reset loads the ID instruction.
    set_id(ADD123, 32'h100, 32'h11, 32'h22);
    step();
    chk("first_instr", idex_reg[31:0], ADD123);
    chk("first_valid", idex_valid, 1'b1);
    chk("first_a", idex_reg[95:64], 32'h11);

    // Load-use: one bubble, then the dependent add.
    set_id(LW5, 32'h104, 32'h40, 32'h0);
    step();
    set_id(ADD657, 32'h108, 32'h55, 32'h77);
    #1 chk("lu_stall", id_stall, 1'b1);
    step();
    chk("lu_bubble_valid", idex_valid, 1'b0);
    chk("lu_bubble_reg", idex_reg, 160'h0);
    chk("lu_cnt", bubble_cnt, 4'h1);
    chk("lu_stall_released", id_stall, 1'b0);
    step();
    chk("lu_add_loaded", idex_reg[31:0], ADD657);
    chk("lu_add_valid", idex_valid, 1'b1);

    // Hold for 3 cycles with a writeback to $3 in the middle.
    set_id(ADD123, 32'h10C, 32'hA, 32'hB);
    step();
    ex_stall = 1'b1;
    set_id(32'h0064_2820, 32'h110, 32'h1, 32'h2);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF; end
      #1 chk("hold_stall", id_stall, 1'b1);
      step();
      wb_we = 1'b0;
      chk("hold_valid", idex_valid, 1'b1);
    end
    chk("hold_b", idex_reg[127:96], 32'hDEADBEEF);
    chk("hold_a", idex_reg[95:64], 32'hA);
    chk("hold_instr", idex_reg[31:0], ADD123);
    ex_stall = 1'b0;

    // rs==rt refresh updates both operands.
    set_id(ADD199, 32'h114, 32'h9, 32'h9);
    step();
    ex_stall = 1'b1; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234_5678;
    step();
    wb_we = 1'b0; ex_stall = 1'b0;
    chk("both_ab", idex_reg[127:64], {32'h1234_5678, 32'h1234_5678});

    // Flush beats stall and load-use.
    set_id(LW5, 32'h118, 32'h40, 32'h0);
    step();
    set_id(ADD657, 32'h11C, 32'h5, 32'h7);
    ex_stall = 1'b1; flush = 1'b1;
    #1 chk("flush_no_stall", id_stall, 1'b0);
    step();
    chk("flush_bubble", {idex_valid, idex_reg}, 161'h0);
    chk("flush_cnt", bubble_cnt, 4'h2);
    ex_stall = 1'b0; flush = 1'b0;

    // Writeback bypass into the incoming operand, and $0 never bypasses.
    set_id(ADD140, 32'h120, 32'h1, 32'h0);
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    step();
    chk("bypass_a", idex_reg[95:64], 32'h55);
    wb_addr = 5'd0;
    step();
    chk("bypass_zero_a", idex_reg[95:64], 32'h1);
    chk("bypass_zero_b", idex_reg[127:96], 32'h0);
    wb_we = 1'b0;

    // Saturation: 20 flushes from a count of 2.
    flush = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 13 || c == 20) chk("sat_cnt", bubble_cnt, 4'hF);
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall.
    set_id(ADD123, 32'h200, 32'h3, 32'h4);
    step();
    ex_stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("areset_reg", idex_reg, 160'h0);
    chk("areset_valid", idex_valid, 1'b0);
    chk("areset_cnt", bubble_cnt, 4'h0);
    chk("areset_stall", id_stall, 1'b0);
    step();
    rst = 1'b0; ex_stall = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures decoded ID-stage operands into the 160-bit idex_reg bundle that the EX-stage decoder and ALU consume.
- Owns load-use hazard detection with bubble insertion, downstream stall hold, and flush.
- While an instruction is held, refreshes its operand fields from the writeback port. Keeps a saturating bubble counter for performance monitoring.

Parameters:
- CNT_W, 16, width of the bubble_cnt performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID stage holds a valid instruction.
- id_instr  in  32  raw instruction word from ID.
- id_pc  in  32  PC of the ID instruction.
- id_rs_data  in  32  register-file read of rs.
- id_rt_data  in  32  register-file read of rt.
- id_imm  in  32  extended immediate; extension is done upstream.
- ex_stall  in  1  EX/MEM cannot accept; hold the current contents.
- flush  in  1  branch/exception kill of the ID/EX contents.
- wb_we  in  1  writeback register write enable.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- idex_reg  out  160  bundle: [31:0] instr, [63:32] pc, [95:64] A (rs value), [127:96] B (rt value), [159:128] imm.
- idex_valid  out  1  idex_reg holds a live instruction.
- id_stall  out  1  to IF/ID: hold the ID instruction this cycle.
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset: asynchronous and active-high. idex_reg=160'h0, idex_valid=0, bubble_cnt=0. id_stall=0 while rst is high.
- Bubble value: idex_reg=0 and idex_valid=0. An all-zero instr decodes as sll $0, which has no architectural effect.
- Load in EX: idex_valid=1 and idex_reg[31:26] is 100011, 100000 or 100100. The load destination is idex_reg[20:16] (rt).
- load_use (combinational): load in EX && id_valid && dest!=0 && (dest==id_instr[25:21] || dest==id_instr[20:16]). Both rs and rt are compared unconditionally.
- Priority at each rising edge, highest first:
  1. flush: load a bubble; bubble_cnt increments.
  2. ex_stall: hold all fields and idex_valid, except the WB refresh below.
  3. load_use: load a bubble; bubble_cnt increments.
  4. Otherwise: load from ID. idex_valid<=id_valid. Fields come from the id_* inputs with WB bypass: A<=wb_data if wb_we && wb_addr!=0 && wb_addr==id_instr[25:21], else id_rs_data. B uses the same rule on id_instr[20:16] and id_rt_data.
- WB refresh during hold (ex_stall && !flush): with idex_valid=1, wb_we, and wb_addr!=0:
  - if wb_addr==held instr[25:21], A<=wb_data;
  - if wb_addr==held instr[20:16], B<=wb_data;
  - both update when rs==rt.
- id_stall (combinational) = !rst && !flush && (ex_stall || load_use). Flush suppresses id_stall; upstream is expected to kill or refetch ID.
- Load-use while ex_stall: hold wins. load_use is re-evaluated on the next edge against the same held load, so the bubble is inserted later.
- bubble_cnt: +1 per inserted bubble. It saturates at all-ones and never wraps.
- Latency: one cycle from ID inputs to idex_reg. No combinational path from id_* to idex_reg.
- $0 writes never refresh or bypass.
- Reset asserted mid-stall or mid-hazard clears the state immediately, without waiting for clk.

Test Plan:
- Reset:
  - Stimulus: rst pulse asynchronous to clk, state loaded beforehand.
  - Response: idex_reg=0, idex_valid=0, bubble_cnt=0 immediately; first post-reset edge with id_valid=1, id_instr=32'h00430820 (add $1,$2,$3) loads instr=32'h00430820, idex_valid=1.
- Load-use:
  - Stimulus: EX holds lw $5,0($1) (32'h8C250000); ID holds add $6,$5,$7.
  - Response: id_stall=1 for one cycle; next edge idex_valid=0, idex_reg=0, bubble_cnt=1; following edge loads the add.
- Hold with WB refresh:
  - Stimulus: ex_stall=1 for 3 cycles, held add $1,$2,$3; in cycle 2, wb_we=1, wb_addr=3, wb_data=32'hDEADBEEF.
  - Response: idex_reg[127:96]=32'hDEADBEEF; A and instr unchanged; idex_valid stays 1; id_stall=1 throughout.
- Flush over stall:
  - Stimulus: flush=1 and ex_stall=1 in the same cycle, with a load-use condition also present.
  - Response: bubble loaded; id_stall=0; bubble_cnt increments by exactly 1.
- WB bypass on load:
  - Stimulus: ID instr rs=4, id_rs_data=32'h1, with wb_we=1, wb_addr=4, wb_data=32'h55 on the same edge.
  - Response: A=32'h55.
  - Stimulus: repeat with wb_addr=0.
  - Response: A=32'h1.
- Counter saturation:
  - Stimulus: CNT_W=4; force 20 consecutive flushes.
  - Response: bubble_cnt=4'hF and stays at 4'hF.
